// File: rtl/window_stream_arbiter.sv
// ---------------------------------------------------------------------------
// window_stream_arbiter
//
// Shares one rts/rtr/sow/eow stream datapath between N_REQ requesters.
// Arbitration is round-robin and happens only between windows: once a
// requester wins, all of its beats up to and including the first accepted
// eow beat are forwarded before anyone else is considered. Each forwarded
// beat carries the index of the requester that produced it.
//
// The master side is fully registered behind a 2-entry out/skid buffer, so
// m_rtr_i never reaches s_rtr_o combinationally.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   s_rts_i[N_REQ]     per-requester ready-to-send
//   s_rtr_o[N_REQ]     per-requester ready-to-receive (only the grantee)
//   s_sow_i, s_eow_i   per-requester start/end of window
//   s_data_i           flattened payloads, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   m_rts_o, m_rtr_i   output beat valid / downstream ready
//   m_sow_o, m_eow_o   window markers of the output beat
//   m_data_o, m_id_o   payload and source requester of the output beat
//   grant_o            one-hot current grant, zero while idle
//   busy_o             high while a window is locked
// ---------------------------------------------------------------------------
module window_stream_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            s_rts_i,
  output logic [N_REQ-1:0]            s_rtr_o,
  input  logic [N_REQ-1:0]            s_sow_i,
  input  logic [N_REQ-1:0]            s_eow_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_data_i,
  output logic                        m_rts_o,
  input  logic                        m_rtr_i,
  output logic                        m_sow_o,
  output logic                        m_eow_o,
  output logic [DATA_WIDTH-1:0]       m_data_o,
  output logic [ID_WIDTH-1:0]         m_id_o,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        busy_o
);

  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_LOCKED = 1'b1;

  localparam int BEAT_WIDTH = 2 + ID_WIDTH + DATA_WIDTH;

  logic [0:0]            state;
  logic [N_REQ-1:0]      grant;
  logic [ID_WIDTH-1:0]   gid;
  logic [ID_WIDTH-1:0]   rr_ptr;

  logic                  found;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   next_rr;
  int                    idx;

  logic                  sel_rts;
  logic                  sel_sow;
  logic                  sel_eow;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic [BEAT_WIDTH-1:0] in_beat;

  logic                  out_valid;
  logic [BEAT_WIDTH-1:0] out_beat;
  logic                  skid_valid;
  logic [BEAT_WIDTH-1:0] skid_beat;

  // Round-robin search: first requesting index at or above rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && s_rts_i[idx[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_WIDTH-1:0];
      end
    end
  end

  assign next_rr = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;

  // The granted requester's signals, selected by its stored index.
  assign sel_rts  = s_rts_i[gid];
  assign sel_sow  = s_sow_i[gid];
  assign sel_eow  = s_eow_i[gid];
  assign sel_data = s_data_i[gid*DATA_WIDTH +: DATA_WIDTH];
  assign in_beat  = {sel_sow, sel_eow, gid, sel_data};

  // A full skid stalls the grantee; grant is zero in IDLE so s_rtr_o is too.
  assign s_rtr_o = grant & {N_REQ{~skid_valid}};
  assign accept  = (state == STATE_LOCKED) & ~skid_valid & sel_rts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STATE_IDLE;
      grant  <= '0;
      gid    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (found) begin
            state  <= STATE_LOCKED;
            grant  <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
            gid    <= winner;
            rr_ptr <= next_rr;
          end
        end
        default: begin
          // The lock is only released by an accepted eow beat; no preemption.
          if (accept && sel_eow) begin
            state <= STATE_IDLE;
            grant <= '0;
          end
        end
      endcase
    end
  end

  // Accepts can only happen with skid empty, so the accept and skid-drain
  // branches are exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else if (accept) begin
      if (!out_valid || m_rtr_i) begin
        out_valid <= 1'b1;
        out_beat  <= in_beat;
      end else begin
        skid_valid <= 1'b1;
        skid_beat  <= in_beat;
      end
    end else if (out_valid && m_rtr_i) begin
      if (skid_valid) begin
        out_beat   <= skid_beat;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_rts_o = out_valid;
  assign {m_sow_o, m_eow_o, m_id_o, m_data_o} = out_beat;
  assign grant_o = grant;
  assign busy_o  = (state == STATE_LOCKED);

endmodule

// File: tb/tb_window_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_window_stream_arbiter
//
// Randomized bench for window_stream_arbiter (N_REQ=4, DATA_WIDTH=16).
// Each requester produces numbered windows of 1..6 beats. A transaction-level
// reference model (owner index, round-robin pointer, queue of up to two
// buffered beats) predicts grant, busy, s_rtr, and the m_* stream every cycle.
// ---------------------------------------------------------------------------
module tb_window_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  typedef struct packed {
    logic          sow;
    logic          eow;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_rts;
  logic [N-1:0]    s_rtr;
  logic [N-1:0]    s_sow;
  logic [N-1:0]    s_eow;
  logic [N*DW-1:0] s_data;
  logic            m_rts;
  logic            m_rtr;
  logic            m_sow;
  logic            m_eow;
  logic [DW-1:0]   m_data;
  logic [IW-1:0]   m_id;
  logic [N-1:0]    grant;
  logic            busy;

  int tests  = 0;
  int failed = 0;

  // reference model state
  int    owner;
  int    rr;
  beat_t q[$];

  // per-requester window generator
  int pos[N];
  int len[N];
  int seq[N];

  window_stream_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_rts_i  (s_rts),
    .s_rtr_o  (s_rtr),
    .s_sow_i  (s_sow),
    .s_eow_i  (s_eow),
    .s_data_i (s_data),
    .m_rts_o  (m_rts),
    .m_rtr_i  (m_rtr),
    .m_sow_o  (m_sow),
    .m_eow_o  (m_eow),
    .m_data_o (m_data),
    .m_id_o   (m_id),
    .grant_o  (grant),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic resetModel();
    owner = -1;
    rr    = 0;
    q.delete();
    for (int k = 0; k < N; k++) begin
      pos[k] = 0;
      len[k] = $urandom_range(1, 6);
    end
  endtask

  // Drive one cycle of random requests; beats reflect each generator's position.
  task automatic applyStimulus(input int p_rts, input int p_rtr);
    for (int k = 0; k < N; k++) begin
      s_rts[k] = ($urandom_range(0, 99) < p_rts);
      s_sow[k] = (pos[k] == 0) || ($urandom_range(0, 15) == 0);
      s_eow[k] = (pos[k] == len[k] - 1);
      s_data[k*DW +: DW] = 16'((k << 12) | (seq[k] & 32'hfff));
    end
    m_rtr = ($urandom_range(0, 99) < p_rtr);
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit    drain;
    bit    acc;
    beat_t b;
    drain = (q.size() > 0) && m_rtr;
    acc   = (owner >= 0) && (q.size() < 2) && s_rts[owner];
    b     = '0;
    if (acc) begin
      b.sow  = s_sow[owner];
      b.eow  = s_eow[owner];
      b.id   = IW'(owner);
      b.data = s_data[owner*DW +: DW];
    end
    if (drain) void'(q.pop_front());
    if (acc) q.push_back(b);
    if (owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (rr + i) % N;
        if (s_rts[k]) begin
          owner = k;
          rr    = (k + 1) % N;
          break;
        end
      end
    end else if (acc) begin
      int k;
      k = owner;
      seq[k]++;
      pos[k]++;
      if (pos[k] == len[k]) begin
        pos[k] = 0;
        len[k] = $urandom_range(1, 6);
      end
      if (b.eow) owner = -1;
    end
  endtask

  task automatic checkCycle();
    logic [N-1:0] exp_grant;
    exp_grant = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    checkOutput("grant", 32'(grant), 32'(exp_grant));
    checkOutput("busy", 32'(busy), 32'(owner >= 0));
    checkOutput("s_rtr", 32'(s_rtr), (q.size() < 2) ? 32'(exp_grant) : 32'd0);
    checkOutput("m_rts", 32'(m_rts), 32'(q.size() > 0));
    if (q.size() > 0) begin
      checkOutput("m_sow", 32'(m_sow), 32'(q[0].sow));
      checkOutput("m_eow", 32'(m_eow), 32'(q[0].eow));
      checkOutput("m_id", 32'(m_id), 32'(q[0].id));
      checkOutput("m_data", 32'(m_data), 32'(q[0].data));
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_s_rtr", 32'(s_rtr), 32'd0);
    checkOutput("rst_m_rts", 32'(m_rts), 32'd0);
    checkOutput("rst_m_sow", 32'(m_sow), 32'd0);
    checkOutput("rst_m_eow", 32'(m_eow), 32'd0);
    checkOutput("rst_m_id", 32'(m_id), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
  endtask

  task automatic runPhase(input int cycles, input int p_rts, input int p_rtr);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      applyStimulus(p_rts, p_rtr);
      @(posedge clk);
      modelStep();
      #1;
      checkCycle();
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) seq[k] = 0;
    rst_n  = 1'b0;
    s_rts  = '0;
    s_sow  = '0;
    s_eow  = '0;
    s_data = '0;
    m_rtr  = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    @(negedge clk);
    rst_n = 1'b1;

    runPhase(200, 100, 100);
    runPhase(600, 60, 70);
    runPhase(300, 80, 15);

    // Asynchronous reset while windows are in flight and buffers are filling.
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    resetModel();
    #2;
    rst_n = 1'b1;

    runPhase(400, 50, 50);
    runPhase(300, 30, 100);
    runPhase(200, 90, 35);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/window_stream_arbiter.md
# window_stream_arbiter

Round-robin arbiter that shares one rts/rtr/sow/eow stream datapath (such as a DELAY-stage `pipeline` instance) between N_REQ upstream requesters. Arbitration happens only at window boundaries. Once a requester is granted, every beat up to and including the first accepted beat with eow=1 is forwarded before another requester is considered. Each forwarded beat is tagged with the requester index so downstream logic can route results back. The master side is fully registered with a 2-entry output/skid buffer, so no combinational path runs from m_rtr_i to s_rtr_o.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 16: payload width.
- ID_WIDTH, $clog2(N_REQ): width of the requester tag.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_rts_i  in  N_REQ  per-requester ready-to-send.
- s_rtr_o  out  N_REQ  per-requester ready-to-receive.
- s_sow_i  in  N_REQ  per-requester start-of-window.
- s_eow_i  in  N_REQ  per-requester end-of-window.
- s_data_i  in  N_REQ*DATA_WIDTH  payloads, flattened; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_rts_o  out  1  output beat valid.
- m_rtr_i  in  1  downstream ready.
- m_sow_o, m_eow_o  out  1  sow/eow of the output beat.
- m_data_o  out  DATA_WIDTH  output payload.
- m_id_o  out  ID_WIDTH  index of the requester that produced the output beat.
- grant_o  out  N_REQ  one-hot current grant; all zeros in IDLE.
- busy_o  out  1  1 while in LOCKED.

## Operation
- Transfer rule: a beat moves on any interface in a cycle where rts=1 and rtr=1. sow/eow/data are sampled only on transfer.
- The FSM has two states: IDLE and LOCKED. Reset state is IDLE, with grant=0 and rr_ptr=0.
- IDLE:
  - Candidates are all k with s_rts_i[k]=1. sow is not required.
  - The winner is the first candidate found by searching upward from rr_ptr, wrapping modulo N_REQ.
  - If there is a winner, the next state is LOCKED, grant_o is set one-hot to the winner, and rr_ptr becomes winner+1 mod N_REQ.
  - If there are no candidates, the FSM stays in IDLE.
- LOCKED:
  - s_rtr_o[g] = grant_o[g] & ~skid_valid. All other s_rtr_o bits are 0.
  - An accepted beat with s_eow_i[g]=1 moves the FSM to IDLE next cycle and clears grant.
  - There is no preemption. If the granted requester drops rts mid-window, the lock is held indefinitely.
  - sow=1 mid-window is passed through unchanged and has no control effect.
- In IDLE, s_rtr_o is 0 for all requesters.
- Output buffer holds two registers, out and skid. Each stores {sow, eow, id, data} plus a valid bit.
  - On accept: if ~out_valid or m_rtr_i, the beat loads into out. Otherwise it loads into skid.
  - If out_valid & m_rtr_i & skid_valid, skid moves to out and skid_valid clears.
  - If out_valid & m_rtr_i with nothing to replace it, out_valid clears.
  - m_rts_o = out_valid. m_* outputs are driven from the out register.
- Reset values: every output is 0, including s_rtr_o, m_rts_o, m_sow_o, m_eow_o, m_data_o, m_id_o, grant_o and busy_o. An asserted rst_n mid-window discards both buffered beats and the lock immediately.

## Timing
- Arbitration latency: requests seen in IDLE at edge t produce grant_o and s_rtr_o[winner] valid during cycle t+1. The first beat can be accepted in cycle t+1.
- Accept-to-output latency: a beat accepted in cycle c appears on m_* in cycle c+1 when out is empty or draining. Otherwise it waits in skid.
- Window gap: an eow beat accepted in cycle c gives IDLE in c+1 and a new grant in c+2. That is one dead cycle on the slave side between windows.
- Throughput: with m_rtr_i held at 1, one beat per cycle inside a window.
- Back-pressure: after m_rtr_i drops, at most one further beat is accepted (into skid), then s_rtr_o falls. No beat is lost or duplicated.
- Simultaneous events: an eow accept and a new rts from another requester in the same cycle are resolved one cycle later in IDLE. The out→m transfer and a new accept in the same cycle are both legal.

## Test plan
- Single requester 0 sends a 3-beat window (sow on beat A, eow on beat C) with m_rtr_i=1 -> grant_o=0001 one cycle after rts, m_* shows A,B,C on consecutive cycles with m_id_o=0, sow/eow on A/C, then grant_o=0.
- All 4 requesters hold rts with 1-beat windows (sow=eow=1) -> grant order 0,1,2,3,0 and m_id_o sequence 0,1,2,3,0, with one dead slave cycle between windows.
- Requester 2 is mid-window and requester 1 raises rts -> requester 1 is not granted until after requester 2's eow beat is accepted; no interleaving appears on m_*.
- Hold m_rtr_i=0 for 5 cycles during a 6-beat window -> exactly 2 beats are buffered, s_rtr_o=0 while skid_valid=1, and after release all 6 beats are output in order.
- Granted requester drops rts for 4 cycles mid-window while other requesters request -> busy_o stays 1 and grant is unchanged; the window resumes and completes.
- Assert rst_n low mid-window with both buffers full -> all outputs read 0 asynchronously; after release, the first grant goes to the lowest-index requester with rts (rr_ptr=0).
